eth_tx_pkt_buf: RTL

ETH_TX_PKT_BUF -- requirements
Module: eth_tx_pkt_buf

---
 rtl/eth_pkg.sv | 16 +
 rtl/eth_sdp_ram.sv | 22 ++
 rtl/eth_tx_pkt_buf.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet TX definitions: byte-lane flag positions and the buffer FSM state codes.
package eth_pkg;

  localparam int BYTE_W  = 10;
  localparam int SOP_BIT = 9;
  localparam int EOP_BIT = 8;

  localparam logic [1:0] WR_IDLE    = 2'd0;
  localparam logic [1:0] WR_PKT     = 2'd1;
  localparam logic [1:0] WR_DISCARD = 2'd2;

  localparam logic [1:0] RD_IDLE = 2'd0;
  localparam logic [1:0] RD_SEND = 2'd1;
  localparam logic [1:0] RD_GAP  = 2'd2;

endpackage

// File: rtl/eth_sdp_ram.sv
// Simple dual-port RAM, one write port and one registered read port (1-cycle read latency).
module eth_sdp_ram #(
  parameter int pDepth = 2048,
  parameter int pWidth = 10
) (
  input  logic                      clk_i,
  input  logic                      we_i,
  input  logic [$clog2(pDepth)-1:0] waddr_i,
  input  logic [pWidth-1:0]         wdata_i,
  input  logic                      re_i,
  input  logic [$clog2(pDepth)-1:0] raddr_i,
  output logic [pWidth-1:0]         rdata_o
);

  logic [pWidth-1:0] mem [pDepth];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/eth_tx_pkt_buf.sv
// Store-and-forward TX packet buffer: a packet is released to eth_tx only after its EOP is committed,
// followed by a forced idle gap; aborted, overflowing or stray input is dropped on the write side.
module eth_tx_pkt_buf
  import eth_pkg::*;
#(
  parameter int pDepth      = 2048,
  parameter int pGap_Cycles = 6144
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [9:0] In_Byte,
  input  logic       In_Byte_Valid,
  output logic       In_Ready,
  output logic [9:0] Eth_Byte,
  output logic       Eth_Byte_Valid,
  output logic [7:0] Pkt_Count,
  output logic       Drop_Pulse
);

  localparam int AW = $clog2(pDepth);
  localparam int PW = AW + 1;
  localparam int GW = (pGap_Cycles > 1) ? $clog2(pGap_Cycles) : 1;

  localparam logic [PW-1:0] FULL_LVL = PW'(pDepth - 1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [GW-1:0] GAP_LAST = GW'(pGap_Cycles - 1);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);

  logic [1:0]        wr_st_q, wr_st_d, rd_st_q, rd_st_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              vld_q, vld_d, drop_q, drop_d;
  logic [PW-1:0]     occ, wbase;
  logic              full, acc, sop, eop, we, re, commit, rel;
  logic [BYTE_W-1:0] rdata;

  assign occ      = wr_ptr_q - rd_ptr_q;
  assign full     = (occ >= FULL_LVL);
  assign In_Ready = !full && (cnt_q != 8'hFF);
  assign acc      = In_Byte_Valid && In_Ready;
  assign sop      = In_Byte[SOP_BIT];
  assign eop      = In_Byte[EOP_BIT];
  // Outside WR_PKT the write pointer equals the commit pointer, so an SOP always starts at cmt_ptr.
  assign wbase    = sop ? cmt_ptr_q : wr_ptr_q;

  always_comb begin
    wr_st_d   = wr_st_q;
    wr_ptr_d  = wr_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    drop_d    = 1'b0;
    we        = 1'b0;
    commit    = 1'b0;
    if (wr_st_q == WR_PKT && In_Byte_Valid && !In_Ready) begin
      wr_ptr_d = cmt_ptr_q;
      drop_d   = 1'b1;
      wr_st_d  = WR_DISCARD;
    end else if (acc && (sop || wr_st_q == WR_PKT)) begin
      drop_d   = sop && (wr_st_q == WR_PKT);
      we       = 1'b1;
      wr_ptr_d = wbase + PTR_ONE;
      if (eop) begin
        cmt_ptr_d = wbase + PTR_ONE;
        commit    = 1'b1;
        wr_st_d   = WR_IDLE;
      end else begin
        wr_st_d = WR_PKT;
      end
    end
  end

  // Reads run one byte ahead of the output; the EOP flag on the current output stops the prefetch.
  always_comb begin
    rd_st_d  = rd_st_q;
    rd_ptr_d = rd_ptr_q;
    gap_d    = gap_q;
    vld_d    = 1'b0;
    re       = 1'b0;
    rel      = 1'b0;
    case (rd_st_q)
      RD_IDLE: begin
        if (cnt_q != 8'd0) begin
          re      = 1'b1;
          vld_d   = 1'b1;
          rd_st_d = RD_SEND;
        end
      end
      RD_SEND: begin
        if (rdata[EOP_BIT]) begin
          rel     = 1'b1;
          gap_d   = '0;
          rd_st_d = RD_GAP;
        end else begin
          re    = 1'b1;
          vld_d = 1'b1;
        end
      end
      RD_GAP: begin
        if (gap_q == GAP_LAST) begin
          if (cnt_q != 8'd0) begin
            re      = 1'b1;
            vld_d   = 1'b1;
            rd_st_d = RD_SEND;
          end else begin
            rd_st_d = RD_IDLE;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
      default: rd_st_d = RD_IDLE;
    endcase
    if (re) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  assign cnt_d = cnt_q + {7'd0, commit} - {7'd0, rel};

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_st_q   <= WR_IDLE;
      rd_st_q   <= RD_IDLE;
      wr_ptr_q  <= '0;
      cmt_ptr_q <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      gap_q     <= '0;
      vld_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      wr_st_q   <= wr_st_d;
      rd_st_q   <= rd_st_d;
      wr_ptr_q  <= wr_ptr_d;
      cmt_ptr_q <= cmt_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      vld_q     <= vld_d;
      drop_q    <= drop_d;
    end
  end

  eth_sdp_ram #(
    .pDepth(pDepth),
    .pWidth(BYTE_W)
  ) u_ram (
    .clk_i  (Clk),
    .we_i   (we),
    .waddr_i(wbase[AW-1:0]),
    .wdata_i(In_Byte),
    .re_i   (re),
    .raddr_i(rd_ptr_q[AW-1:0]),
    .rdata_o(rdata)
  );

  assign Eth_Byte_Valid = vld_q;
  assign Eth_Byte       = vld_q ? rdata : '0;
  assign Pkt_Count      = cnt_q;
  assign Drop_Pulse     = drop_q;

endmodule
